// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO family.
//   FWFT_OFF / FWFT_ON : read-mode selectors for the FWFT parameter
//   ptr_width()        : bits needed to address 0..depth-1 (minimum 1)
//   count_width()      : bits needed to hold an occupancy of 0..depth
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // Address width for a storage array of 'depth' words.
    function automatic int ptr_width(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

    // Width able to represent every occupancy value from 0 to depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// DATA_DEPTH x DATA_WIDTH register array with one synchronous write port and
// one read port. With FWFT=0 the read port is registered (data appears the
// cycle after rd_en); with FWFT=1 it is a combinational view of rd_addr so the
// head word is always presented.
// Ports:
//   clk      : clock, rising edge
//   rst      : async active-high reset (clears only the read register)
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe (registered mode only)
//   rd_addr  : read address
//   rd_data  : read data
// -----------------------------------------------------------------------------
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 64,
    parameter int FWFT       = FWFT_OFF,
    parameter int ADDR_W     = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // The array itself is never reset; occupancy tracking in the parent makes
    // stale contents unreachable.
    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    generate
        if (FWFT == FWFT_ON) begin : g_head_read
            // Head word is visible as soon as it has been written.
            assign rd_data = mem_q[rd_addr];

            logic unused_rd_s;
            assign unused_rd_s = rst ^ rd_en;
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] rd_data_q;

            // Registered read port: loads on an accepted read, holds otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q <= {DATA_WIDTH{1'b0}};
                end else if (rd_en) begin
                    rd_data_q <= mem_q[rd_addr];
                end else begin
                    rd_data_q <= rd_data_q;
                end
            end

            assign rd_data = rd_data_q;
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO of any depth >= 2 (power of two not required), with
// standard (1-cycle read latency) or first-word-fall-through read mode,
// occupancy count, full/empty/almost flags and one-cycle overflow/underflow
// error pulses.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   wr_en        : write request, accepted when not full
//   data_in      : write data
//   rd_en        : read request, accepted when not empty
//   data_out     : read data (FWFT=0: registered; FWFT=1: head word)
//   data_valid   : data_out holds a valid word
//   full, empty  : count==DATA_DEPTH / count==0
//   almost_full  : count >= AFULL_LVL
//   almost_empty : count <= AEMPTY_LVL
//   count        : number of stored words
//   overflow     : pulses the cycle after a rejected write
//   underflow    : pulses the cycle after a rejected read
// -----------------------------------------------------------------------------
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 64,
    parameter int FWFT       = FWFT_OFF,
    parameter int AFULL_LVL  = DATA_DEPTH - 4,
    parameter int AEMPTY_LVL = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_en,
    input  logic [DATA_WIDTH-1:0]               data_in,
    input  logic                                rd_en,
    output logic [DATA_WIDTH-1:0]               data_out,
    output logic                                data_valid,
    output logic                                full,
    output logic                                empty,
    output logic                                almost_full,
    output logic                                almost_empty,
    output logic [count_width(DATA_DEPTH)-1:0]  count,
    output logic                                overflow,
    output logic                                underflow
);

    localparam int PTR_W = ptr_width(DATA_DEPTH);
    localparam int CNT_W = count_width(DATA_DEPTH);

    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DATA_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DATA_DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT  = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(AEMPTY_LVL);

    // Reject unusable parameter sets while elaborating.
    generate
        if ((DATA_DEPTH < 2) || (DATA_WIDTH < 1) ||
            (AFULL_LVL < 1) || (AFULL_LVL > DATA_DEPTH) ||
            (AEMPTY_LVL < 0) || (AEMPTY_LVL > DATA_DEPTH - 1) ||
            ((FWFT != FWFT_OFF) && (FWFT != FWFT_ON))) begin : g_bad_params
            $error("sync_fifo_param: illegal DATA_DEPTH/AFULL_LVL/AEMPTY_LVL/FWFT");
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             valid_q, valid_d;

    logic             full_s;
    logic             empty_s;
    logic             wr_acc_s;
    logic             rd_acc_s;
    logic [DATA_WIDTH-1:0] ram_rd_data_s;

    // Flags come only from the registered count, so wr_en/rd_en never reach
    // them combinationally.
    assign full_s  = (count_q == DEPTH_CNT);
    assign empty_s = (count_q == {CNT_W{1'b0}});

    // Acceptance, pointer wrap, occupancy and error-pulse next state.
    always_comb begin
        wr_acc_s    = wr_en & ~full_s;
        rd_acc_s    = rd_en & ~empty_s;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = wr_en & full_s;
        underflow_d = rd_en & empty_s;
        valid_d     = rd_acc_s;

        // Explicit wrap at DATA_DEPTH-1 keeps non-power-of-two depths correct.
        if (wr_acc_s) begin
            if (wr_ptr_q == LAST_PTR) begin
                wr_ptr_d = {PTR_W{1'b0}};
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            if (rd_ptr_q == LAST_PTR) begin
                rd_ptr_d = {PTR_W{1'b0}};
            end else begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, occupancy, valid and error-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            valid_q     <= valid_d;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .FWFT       (FWFT),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc_s),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (rd_acc_s),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data_s)
    );

    generate
        if (FWFT == FWFT_ON) begin : g_fwft_out
            // Head word is shown only while something is stored, so an empty
            // FIFO presents zero rather than stale or unwritten storage.
            assign data_valid = ~empty_s;
            assign data_out   = empty_s ? {DATA_WIDTH{1'b0}} : ram_rd_data_s;

            logic unused_valid_s;
            assign unused_valid_s = valid_q;
        end else begin : g_std_out
            assign data_valid = valid_q;
            assign data_out   = ram_rd_data_s;
        end
    endgenerate

    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_q >= AFULL_CNT);
    assign almost_empty = (count_q <= AEMPTY_CNT);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: data bits per word.
REQ-002 SHALL have parameter DATA_DEPTH, default 64: number of words, any integer >= 2 (not restricted to powers of two).
REQ-003 SHALL have parameter FWFT, default 0: 0 = standard read mode, 1 = first-word-fall-through mode.
REQ-004 SHALL have parameter AFULL_LVL, default DATA_DEPTH-4: almost_full threshold, in words.
REQ-005 SHALL have parameter AEMPTY_LVL, default 4: almost_empty threshold, in words.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port wr_en, input, 1 bit: write request.
REQ-009 SHALL have port data_in, input, DATA_WIDTH bits: write data.
REQ-010 SHALL have port rd_en, input, 1 bit: read request.
REQ-011 SHALL have port data_out, output, DATA_WIDTH bits: read data.
REQ-012 SHALL have port data_valid, output, 1 bit: data_out holds a valid word.
REQ-013 SHALL have ports full, empty, almost_full and almost_empty, each output, 1 bit: status flags.
REQ-014 SHALL have port count, output, $clog2(DATA_DEPTH+1) bits: current number of stored words.
REQ-015 SHALL have ports overflow and underflow, each output, 1 bit: one-cycle error pulses.

Function
REQ-016 Write acceptance: a write SHALL be accepted when wr_en=1 and full=0; the word is stored at wr_ptr and wr_ptr advances.
REQ-017 Read acceptance: a read SHALL be accepted when rd_en=1 and empty=0; rd_ptr advances.
REQ-018 Pointer wrap: wr_ptr and rd_ptr SHALL be 0..DATA_DEPTH-1 and wrap from DATA_DEPTH-1 to 0, for non-power-of-two depths too.
REQ-019 Count: count SHALL be registered and SHALL change by +1 on write only, -1 on read only, and 0 on an accepted simultaneous read and write.
REQ-020 Full and empty: full SHALL equal (count==DATA_DEPTH) and empty SHALL equal (count==0); both are derived from registered state, with no combinational path from wr_en or rd_en.
REQ-021 Almost flags: almost_full SHALL equal (count>=AFULL_LVL) and almost_empty SHALL equal (count<=AEMPTY_LVL).
REQ-022 Simultaneous read and write at empty: only the write SHALL be accepted; underflow pulses if rd_en=1.
REQ-023 Simultaneous read and write at full: only the read SHALL be accepted; overflow pulses and count goes to DATA_DEPTH-1.
REQ-024 Overflow: overflow SHALL pulse high for the one cycle after a rejected write (wr_en=1 while full=1); memory and wr_ptr are unchanged.
REQ-025 Underflow: underflow SHALL pulse high for the one cycle after a rejected read (rd_en=1 while empty=1); data_out is unchanged.
REQ-026 FWFT=0: data_out SHALL load mem[rd_ptr] on the edge that accepts a read, giving 1-cycle latency, and hold otherwise.
REQ-027 FWFT=0: data_valid SHALL pulse high for the cycle following an accepted read.
REQ-028 FWFT=1: data_out SHALL present the head word, and data_valid SHALL equal ~empty.
REQ-029 FWFT=1: an accepted read SHALL consume the presented word; the next word, or invalid, appears the next cycle.
REQ-030 FWFT=1: a word written into an empty FIFO SHALL appear on data_out one cycle after the write edge.
REQ-031 Parameter legality: AFULL_LVL SHALL be in 1..DATA_DEPTH and AEMPTY_LVL in 0..DATA_DEPTH-1; illegal values are flagged by an elaboration-time check.

Reset
REQ-032 While rst=1, and immediately on its assertion: wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0 (for AFULL_LVL>0), overflow=0, underflow=0, data_valid=0, data_out=0.
REQ-033 Mid-operation reset SHALL discard all stored words.
REQ-034 The storage array SHALL NOT be reset.
REQ-035 After rst deasserts, the first accepted write SHALL be the first word read.

Structure
REQ-036 A shared package fifo_pkg SHALL hold the pointer-width and count-width helper functions (clog2-based) and the mode constants FWFT_OFF=0 and FWFT_ON=1.
REQ-037 Storage SHALL be a sub-module fifo_ram: a DATA_DEPTH x DATA_WIDTH register array with one synchronous write port and one read port (registered for FWFT=0, combinational head for FWFT=1).
REQ-038 Pointers, count, flags and output logic SHALL live in sync_fifo_param.

Verification
REQ-039 Reset then idle: DEPTH=8, WIDTH=8, rst pulse -> empty=1, count=0, data_valid=0, data_out=0, full=0.
REQ-040 Fill to full: 8 writes 0x01..0x08, then a 9th write 0xFF -> full=1, count=8, overflow pulses 1 cycle; reading all 8 returns 0x01..0x08 in order and 0xFF never appears.
REQ-041 Underflow: rd_en=1 while empty -> underflow pulses 1 cycle, count stays 0, data_out unchanged.
REQ-042 Non-power-of-two wrap: DEPTH=6, 20 write/read pairs with data 0..19 -> output 0..19 in order, pointers wrap at 5->0, count never exceeds 6.
REQ-043 Simultaneous operations: at count=3, rd_en=wr_en=1 for 5 cycles -> count stays 3, almost_empty (AEMPTY_LVL=4) stays 1; at full, simultaneous rd/wr -> count=7 and overflow=1.
REQ-044 Modes and reset: FWFT=1, write 0xA5 into empty -> data_out=0xA5 and data_valid=1 on the next cycle with no rd_en; assert rst at count=5 -> empty=1 and count=0 immediately.
